rtc_event_sched: RTL

- Shared timestamp scheduler in front of the RTC running counters (sec/usec).
- Several asynchronous-origin event sources each need the exact RTC time of their event: sensor frame start, external trigger, GPS PPS, and CPU software strobe.
- Each source gets a per-source snapshot register taken on its event edge. A round-robin arbiter then shares a single FIFO write port among the sources.
- The CPU drains the FIFO as {src, sec, usec} records.

---
 rtl/rtc_event_pkg.sv | 27 ++
 rtl/rtc_ts_fifo.sv | 81 ++++++++
 rtl/rtc_event_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/rtc_event_pkg.sv
// Shared constants for the RTC event timestamp scheduler: timestamp widths,
// record layout {src, sec, usec} and the fixed source-id assignments.
package rtc_event_pkg;

  localparam int TS_SEC_W  = 32;
  localparam int TS_USEC_W = 20;
  localparam int TS_W      = TS_SEC_W + TS_USEC_W;

  // Bit offsets inside a record; the source id sits above the timestamp.
  localparam int REC_USEC_LSB = 0;
  localparam int REC_SEC_LSB  = TS_USEC_W;
  localparam int REC_SRC_LSB  = TS_W;

  typedef enum logic [2:0] {
    SRC_FRAME = 3'd0,
    SRC_TRIG  = 3'd1,
    SRC_PPS   = 3'd2,
    SRC_SW    = 3'd3
  } src_id_e;

  // Packs a coherent RTC sample into the timestamp part of a record.
  function automatic logic [TS_W-1:0] pack_ts(input logic [TS_SEC_W-1:0] s,
                                              input logic [TS_USEC_W-1:0] u);
    return {s, u};
  endfunction

endpackage

// File: rtl/rtc_ts_fifo.sv
// First-word-fall-through FIFO holding timestamp records. The head word and
// valid flag are registers, so the consumer sees a clean registered record.
// All state changes on the falling edge of mclk.
module rtc_ts_fifo
  import rtc_event_pkg::*;
#(
  parameter int W  = 55,
  parameter int AW = 4
) (
  input  logic          mclk,
  input  logic          rst,
  input  logic          we,
  input  logic [W-1:0]  wd,
  input  logic          rd,
  output logic          valid,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_ZERO = (AW+1)'(0);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] rptr_inc;
  logic          push;
  logic          pop;
  logic [AW:0]   count_nxt;
  logic [W-1:0]  head_nxt;

  // Next occupancy and next head word, including the empty fall-through case.
  always_comb begin
    push     = we & (count != CNT_FULL);
    pop      = rd & valid;
    rptr_inc = rptr + AW'(1);
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
    if (pop && (count > CNT_ONE)) begin
      head_nxt = mem[rptr_inc];
    end else if ((pop || (count == CNT_ZERO)) && push) begin
      head_nxt = wd;
    end else begin
      head_nxt = rdata;
    end
  end

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(negedge mclk) begin
    if (push) begin
      mem[wptr] <= wd;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(negedge mclk) begin
    if (rst) begin
      wptr  <= AW'(0);
      rptr  <= AW'(0);
      count <= CNT_ZERO;
      valid <= 1'b0;
      rdata <= W'(0);
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr_inc;
      end
      count <= count_nxt;
      valid <= (count_nxt != CNT_ZERO);
      rdata <= head_nxt;
    end
  end

endmodule

// File: rtl/rtc_event_sched.sv
// RTC event timestamp scheduler. Each source snapshots {sec, usec} on its
// rising event edge into a private register; a round-robin arbiter then moves
// one pending snapshot per cycle into the shared record FIFO.
module rtc_event_sched
  import rtc_event_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int SW   = 3,
  parameter int AW   = 4
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic [NSRC-1:0]       ev_req,
  input  logic [NSRC-1:0]       ev_en,
  input  logic [TS_SEC_W-1:0]   sec,
  input  logic [TS_USEC_W-1:0]  usec,
  input  logic                  rd,
  input  logic                  clr_lost,
  output logic                  ts_valid,
  output logic [SW-1:0]         ts_src,
  output logic [TS_SEC_W-1:0]   ts_sec,
  output logic [TS_USEC_W-1:0]  ts_usec,
  output logic [AW:0]           fifo_count,
  output logic [NSRC-1:0]       lost
);

  localparam int RW    = SW + TS_W;
  localparam int DEPTH = 1 << AW;

  logic [NSRC-1:0] ev_d;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] ev_edge;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] gnt_vec;
  logic            gnt_valid;
  logic [SW-1:0]   gnt_idx;
  logic [SW-1:0]   rr;
  logic [TS_W-1:0] snap [NSRC];
  logic [TS_W-1:0] gnt_snap;
  logic            full;
  logic [RW-1:0]   wd;
  logic [RW-1:0]   rdata;
  logic            hit;

  // Edge detect and round-robin pick: sources above rr first, then wrap.
  always_comb begin
    full      = (fifo_count == (AW+1)'(DEPTH));
    ev_edge   = ev_req & ~ev_d & ev_en;
    req       = pend & {NSRC{~full}};
    gnt_valid = 1'b0;
    gnt_idx   = SW'(0);
    gnt_vec   = NSRC'(0);
    gnt_snap  = TS_W'(0);
    hit       = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      hit        = req[i] & (SW'(i) > rr) & ~gnt_valid;
      gnt_vec[i] = hit;
      gnt_idx    = hit ? SW'(i) : gnt_idx;
      gnt_valid  = gnt_valid | hit;
    end
    for (int i = 0; i < NSRC; i++) begin
      hit        = req[i] & (SW'(i) <= rr) & ~gnt_valid;
      gnt_vec[i] = gnt_vec[i] | hit;
      gnt_idx    = hit ? SW'(i) : gnt_idx;
      gnt_valid  = gnt_valid | hit;
    end
    for (int i = 0; i < NSRC; i++) begin
      gnt_snap = gnt_snap | ({TS_W{gnt_vec[i]}} & snap[i]);
    end
    wd = {gnt_idx, gnt_snap};
  end

  // Snapshots, pending/lost flags and the round-robin pointer.
  always_ff @(negedge mclk) begin
    if (rst) begin
      ev_d <= ev_req;
      pend <= NSRC'(0);
      lost <= NSRC'(0);
      rr   <= SW'(NSRC - 1);
      for (int i = 0; i < NSRC; i++) begin
        snap[i] <= TS_W'(0);
      end
    end else begin
      ev_d <= ev_req;
      pend <= (pend & ~gnt_vec) | ev_edge;
      // A drop in this cycle beats a simultaneous clear.
      lost <= (ev_edge & pend & ~gnt_vec) | (lost & ~{NSRC{clr_lost}});
      if (gnt_valid) begin
        rr <= gnt_idx;
      end
      for (int i = 0; i < NSRC; i++) begin
        if (ev_edge[i] && (!pend[i] || gnt_vec[i])) begin
          snap[i] <= pack_ts(sec, usec);
        end
      end
    end
  end

  rtc_ts_fifo #(
    .W  (RW),
    .AW (AW)
  ) u_fifo (
    .mclk  (mclk),
    .rst   (rst),
    .we    (gnt_valid),
    .wd    (wd),
    .rd    (rd),
    .valid (ts_valid),
    .rdata (rdata),
    .count (fifo_count)
  );

  assign ts_src  = rdata[REC_SRC_LSB  +: SW];
  assign ts_sec  = rdata[REC_SEC_LSB  +: TS_SEC_W];
  assign ts_usec = rdata[REC_USEC_LSB +: TS_USEC_W];

endmodule
